// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: state encoding, access sizes and the
// idle memory-port request driven when nobody holds the grant.
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        ST_CORE = 1'b0,
        ST_HOST = 1'b1
    } arb_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } mem_req_t;

    localparam logic [31:0] IDLE_ADDR  = 32'h0000_0000;
    localparam logic [31:0] IDLE_WDATA = 32'h0000_0000;
    localparam logic [1:0]  IDLE_SIZE  = SZ_WORD;

    localparam mem_req_t MEM_IDLE = '{
        wr:    1'b0,
        addr:  IDLE_ADDR,
        wdata: IDLE_WDATA,
        size:  IDLE_SIZE
    };

    function automatic mem_req_t pack_req(input logic        wr,
                                          input logic [31:0] addr,
                                          input logic [31:0] wdata,
                                          input logic [1:0]  size);
        mem_req_t r;
        r.wr    = wr;
        r.addr  = addr;
        r.wdata = wdata;
        r.size  = size;
        return r;
    endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at Limit until cleared.
module arb_sat_counter #(
    parameter int unsigned Width = 4,
    parameter int unsigned Limit = 15
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    localparam logic [Width-1:0] LimitW = Width'(Limit);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LimitW)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the single data-memory port: core priority, starvation-forced host grant,
// locked host bursts. Define DMEM_ARB_STATS_EN to add stall/beat statistics counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned BURST_MAX  = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        core_req_i,
    input  logic        core_wr_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    input  logic [1:0]  core_size_i,
    output logic        core_stall_o,
    output logic [31:0] core_rdata_o,
    input  logic        host_req_i,
    input  logic        host_lock_i,
    input  logic        host_wr_i,
    input  logic [31:0] host_addr_i,
    input  logic [31:0] host_wdata_i,
    input  logic [1:0]  host_size_i,
    output logic        host_gnt_o,
    output logic [31:0] host_rdata_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_wr_o,
    output logic [1:0]  mem_size_o,
    input  logic [31:0] mem_rdata_i
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0] stat_core_stalls_o,
    output logic [31:0] stat_host_beats_o
`endif
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
        $error("STARVE_MAX out of range 1..15");
    end
    if (BURST_MAX < 1 || BURST_MAX > 255) begin : g_bad_burst
        $error("BURST_MAX out of range 1..255");
    end

    localparam logic [3:0] StarveLim = 4'(STARVE_MAX);
    localparam logic [7:0] BurstLast = 8'(BURST_MAX - 1);
    localparam bit         BurstEn   = (BURST_MAX > 1);

    arb_state_e state_q, state_d;
    logic [3:0] starve_cnt;
    logic [7:0] burst_cnt;
    logic       starve_sat;
    logic       burst_last;
    logic       gnt_core;
    logic       gnt_host;
    mem_req_t   sel_req;

    assign starve_sat = (starve_cnt == StarveLim);
    assign burst_last = (burst_cnt == BurstLast);

    // Grants are combinational and used in the same cycle; nothing is granted during reset.
    always_comb begin
        gnt_core = 1'b0;
        gnt_host = 1'b0;
        if (!reset_i) begin
            unique case (state_q)
                ST_CORE: begin
                    if (core_req_i && !starve_sat) begin
                        gnt_core = 1'b1;
                    end else if (host_req_i) begin
                        gnt_host = 1'b1;
                    end
                end
                ST_HOST: begin
                    if (host_req_i) begin
                        gnt_host = 1'b1;
                    end else if (core_req_i) begin
                        gnt_core = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_CORE: begin
                if (gnt_host && host_lock_i && BurstEn) begin
                    state_d = ST_HOST;
                end
            end
            ST_HOST: begin
                if (!host_req_i || !host_lock_i || (gnt_host && burst_last)) begin
                    state_d = ST_CORE;
                end
            end
            default: state_d = ST_CORE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_CORE;
        end else begin
            state_q <= state_d;
        end
    end

    arb_sat_counter #(
        .Width (4),
        .Limit (STARVE_MAX)
    ) u_starve_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (gnt_host | ~host_req_i),
        .inc_i   (host_req_i & ~gnt_host),
        .cnt_o   (starve_cnt)
    );

    // Held at zero outside a burst so every entry into ST_HOST starts from beat 0.
    arb_sat_counter #(
        .Width (8),
        .Limit (255)
    ) u_burst_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (state_q == ST_CORE),
        .inc_i   ((state_q == ST_HOST) & gnt_host),
        .cnt_o   (burst_cnt)
    );

    always_comb begin
        sel_req = MEM_IDLE;
        if (gnt_core) begin
            sel_req = pack_req(core_wr_i, core_addr_i, core_wdata_i, core_size_i);
        end else if (gnt_host) begin
            sel_req = pack_req(host_wr_i, host_addr_i, host_wdata_i, host_size_i);
        end
    end

    assign mem_wr_o    = sel_req.wr;
    assign mem_addr_o  = sel_req.addr;
    assign mem_wdata_o = sel_req.wdata;
    assign mem_size_o  = sel_req.size;

    assign core_stall_o = core_req_i & ~gnt_core;
    assign host_gnt_o   = gnt_host;
    assign core_rdata_o = (gnt_core && !core_wr_i) ? mem_rdata_i : 32'h0;
    assign host_rdata_o = (gnt_host && !host_wr_i) ? mem_rdata_i : 32'h0;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_core_stalls_q;
    logic [31:0] stat_host_beats_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_core_stalls_q <= 32'h0;
            stat_host_beats_q  <= 32'h0;
        end else begin
            if (core_stall_o) begin
                stat_core_stalls_q <= stat_core_stalls_q + 32'd1;
            end
            if (gnt_host) begin
                stat_host_beats_q <= stat_host_beats_q + 32'd1;
            end
        end
    end

    assign stat_core_stalls_o = stat_core_stalls_q;
    assign stat_host_beats_o  = stat_host_beats_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed vectors push expected port values, a negedge
// monitor pops and compares them; a small word memory models dmem.
module tb_dmem_arbiter;

    localparam logic [1:0] SZW = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_wr, core_stall;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [1:0]  core_size;
    logic        host_req, host_lock, host_wr, host_gnt;
    logic [31:0] host_addr, host_wdata, host_rdata;
    logic [1:0]  host_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr;
    logic [1:0]  mem_size;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_core_stalls, stat_host_beats;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(
        .STARVE_MAX (4),
        .BURST_MAX  (8)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .core_req_i   (core_req),
        .core_wr_i    (core_wr),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .core_size_i  (core_size),
        .core_stall_o (core_stall),
        .core_rdata_o (core_rdata),
        .host_req_i   (host_req),
        .host_lock_i  (host_lock),
        .host_wr_i    (host_wr),
        .host_addr_i  (host_addr),
        .host_wdata_i (host_wdata),
        .host_size_i  (host_size),
        .host_gnt_o   (host_gnt),
        .host_rdata_o (host_rdata),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_wr_o     (mem_wr),
        .mem_size_o   (mem_size),
        .mem_rdata_i  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_core_stalls_o (stat_core_stalls),
        .stat_host_beats_o  (stat_host_beats)
`endif
    );

    // dmem model: word-addressed, combinational read, preloaded with A000_000i.
    logic [31:0] mem [16];
    bit          mem_loaded = 1'b0;
    assign mem_rdata = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 | i;
            mem_loaded <= 1'b1;
        end else if (mem_wr) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    typedef struct {
        string       name;
        bit          hg;
        bit          cs;
        bit          mw;
        logic [31:0] ma;
        logic [1:0]  ms;
        logic [31:0] crd;
        logic [31:0] hrd;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          total = 0;
    int          bad = 0;
    int          exp_stalls = 0;
    int          exp_beats = 0;
    logic [1:0]  csz = 2'b11;
    bit          final_req = 1'b0;
    bit          final_done = 1'b0;

    function automatic exp_t ex(input string n, input bit hg, input bit cs, input bit mw,
                                input logic [31:0] ma, input logic [1:0] ms,
                                input logic [31:0] crd, input logic [31:0] hrd);
        exp_t e;
        e.name = n; e.hg = hg; e.cs = cs; e.mw = mw;
        e.ma = ma; e.ms = ms; e.crd = crd; e.hrd = hrd;
        return e;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", n, act, req);
        end
    endtask

    task automatic step(input bit rst, input bit creq, input bit cwr, input logic [31:0] caddr,
                        input logic [31:0] cwd, input bit hreq, input bit hlock, input bit hwr,
                        input logic [31:0] haddr, input logic [31:0] hwd, input exp_t e);
        @(posedge clk);
        #1;
        reset = rst;
        core_req = creq; core_wr = cwr; core_addr = caddr; core_wdata = cwd; core_size = csz;
        host_req = hreq; host_lock = hlock; host_wr = hwr; host_addr = haddr;
        host_wdata = hwd; host_size = SZW;
        sb.push_back(e);
        if (rst) begin
            exp_stalls = 0;
            exp_beats = 0;
        end else begin
            exp_stalls += int'(e.cs);
            exp_beats += int'(e.hg);
        end
    endtask

    // Monitor: the DUT presents a response every cycle; compare it against the queued entry.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            chk({cur.name, ".host_gnt"}, {31'h0, host_gnt}, {31'h0, cur.hg});
            chk({cur.name, ".core_stall"}, {31'h0, core_stall}, {31'h0, cur.cs});
            chk({cur.name, ".mem_wr"}, {31'h0, mem_wr}, {31'h0, cur.mw});
            chk({cur.name, ".mem_addr"}, mem_addr, cur.ma);
            chk({cur.name, ".mem_size"}, {30'h0, mem_size}, {30'h0, cur.ms});
            chk({cur.name, ".core_rdata"}, core_rdata, cur.crd);
            chk({cur.name, ".host_rdata"}, host_rdata, cur.hrd);
        end else if (final_req && !final_done) begin
            chk("mem_0x10", mem[4], 32'hDEAD_BEEF);
            chk("mem_0x20", mem[8], 32'hCAFE_F00D);
            chk("mem_0x24", mem[9], 32'h1111_2222);
`ifdef DMEM_ARB_STATS_EN
            chk("stat_core_stalls", stat_core_stalls, exp_stalls);
            chk("stat_host_beats", stat_host_beats, exp_beats);
`endif
            final_done = 1'b1;
        end
    end

    initial begin
        reset = 1'b1;
        core_req = 0; core_wr = 0; core_addr = 0; core_wdata = 0; core_size = SZW;
        host_req = 0; host_lock = 0; host_wr = 0; host_addr = 0; host_wdata = 0;
        host_size = SZW;

        // Reset with both requesting: nothing granted, core stalled.
        repeat (2) step(1, 1, 1, 32'h30, 32'h55, 1, 0, 0, 32'h14, 0,
                        ex("rst", 0, 1, 0, 0, SZW, 0, 0));
        step(0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 0,
             ex("core_st", 0, 0, 1, 32'h10, SZW, 0, 0));
        step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0,
             ex("core_ld", 0, 0, 0, 32'h10, SZW, 32'hDEAD_BEEF, 0));
        step(0, 0, 0, 32'h10, 0, 0, 0, 0, 32'h14, 0, ex("idle", 0, 0, 0, 0, SZW, 0, 0));
        csz = 2'b10;
        step(0, 1, 0, 32'h04, 0, 0, 0, 0, 0, 0,
             ex("size10", 0, 0, 0, 32'h04, 2'b10, 32'hA000_0001, 0));
        csz = SZW;
        step(0, 0, 0, 0, 0, 1, 0, 0, 32'h08, 0,
             ex("host_ld", 1, 0, 0, 32'h08, SZW, 0, 32'hA000_0002));

        // Contention without lock: host forced every 5th cycle.
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 32'h0C, 0, 1, 0, 0, 32'h14, 0, (i % 5 == 4) ?
                 ex("fair_h", 1, 1, 0, 32'h14, SZW, 0, 32'hA000_0005) :
                 ex("fair_c", 0, 0, 0, 32'h0C, SZW, 32'hA000_0003, 0));
        end

        // Locked burst: forced grant plus 8 beats, then core.
        for (int i = 0; i < 14; i++) begin
            step(0, 1, 0, 32'h0C, 0, 1, 1, 0, 32'h14, 0, (i >= 4 && i <= 12) ?
                 ex("burst_h", 1, 1, 0, 32'h14, SZW, 0, 32'hA000_0005) :
                 ex("burst_c", 0, 0, 0, 32'h0C, SZW, 32'hA000_0003, 0));
        end

        // host_req dropped after 4 host beats: core immediately, and ST_CORE afterwards.
        for (int j = 0; j < 10; j++) begin
            step(0, 1, 0, 32'h0C, 0, (j != 7), 1, 0, 32'h14, 0, (j >= 3 && j <= 6) ?
                 ex("drop_h", 1, 1, 0, 32'h14, SZW, 0, 32'hA000_0005) :
                 ex("drop_c", 0, 0, 0, 32'h0C, SZW, 32'hA000_0003, 0));
        end

        // Reset mid-burst: counters restart, so host waits 4 core cycles again.
        for (int k = 0; k < 10; k++) begin
            step((k == 4), 1, 0, 32'h0C, 0, 1, (k != 9), 0, 32'h14, 0,
                 (k == 4) ? ex("mid_rst", 0, 1, 0, 0, SZW, 0, 0) :
                 (k == 2 || k == 3 || k == 9) ?
                 ex("rb_h", 1, 1, 0, 32'h14, SZW, 0, 32'hA000_0005) :
                 ex("rb_c", 0, 0, 0, 32'h0C, SZW, 32'hA000_0003, 0));
        end

        // Core store held off by a host write burst; it must not reach memory until granted.
        step(0, 0, 0, 0, 0, 1, 1, 1, 32'h24, 32'h1111_2222,
             ex("hst_w", 1, 0, 1, 32'h24, SZW, 0, 0));
        repeat (2) step(0, 1, 1, 32'h20, 32'hCAFE_F00D, 1, 1, 1, 32'h24, 32'h1111_2222,
                        ex("stall_st", 1, 1, 1, 32'h24, SZW, 0, 0));
        step(0, 1, 1, 32'h20, 32'hCAFE_F00D, 0, 1, 1, 32'h24, 32'h1111_2222,
             ex("core_st2", 0, 0, 1, 32'h20, SZW, 0, 0));
        step(0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0,
             ex("core_ld2", 0, 0, 0, 32'h20, SZW, 32'hCAFE_F00D, 0));

        @(posedge clk);
        #1;
        core_req = 0; host_req = 0; host_lock = 0; core_wr = 0; host_wr = 0;
        final_req = 1'b1;
        for (int w = 0; w < 20 && !final_done; w++) @(posedge clk);
        if (!final_done) begin
            bad++;
            total++;
            $display("FAIL drain: actual=%0d entries left required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
